pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 tb/tb_pc_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: four-state instruction sequencer (IDLE, FETCH, DECODE, EXEC)
// holding a 30-bit word-address program counter and the latched instruction.
// Optional trap/exception-return logic is compiled in when the macro
// PC_SEQ_TRAP_EN is defined. Without it, exc, eret and rs_val[1:0] are
// ignored and epc reads as zero.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_4180
) (
  input  logic        clock,
  input  logic        flag_reset,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  input  logic [1:0]  npc_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_val,
  input  logic        stall,
  input  logic        exc,
  input  logic        eret,
  output logic [31:2] pc,
  output logic        imem_req,
  output logic [31:0] instr_q,
  output logic        instr_valid,
  output logic [31:2] epc
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    EXEC   = 2'd3
  } state_t;

  state_t      state_reg;
  logic [29:0] pc_reg;
  logic [31:0] instr_q_reg;
  logic        imem_req_reg;
  logic        instr_valid_reg;

  logic [29:0] pc_plus1;
  logic [29:0] br_off;
  logic [29:0] npc_next;

  assign pc_plus1 = pc_reg + 30'd1;
  // Branch offset is a signed word count taken from the low half of the instruction.
  assign br_off   = {{14{instr_q_reg[15]}}, instr_q_reg[15:0]};

  // Next sequential/branch/jump/register target; all sums wrap at 30 bits.
  always_comb begin
    npc_next = pc_plus1;
    case (npc_sel)
      2'b01:   npc_next = br_taken ? (pc_plus1 + br_off) : pc_plus1;
      2'b10:   npc_next = {pc_plus1[29:26], instr_q_reg[25:0]};
      2'b11:   npc_next = rs_val[31:2];
      default: npc_next = pc_plus1;
    endcase
  end

`ifdef PC_SEQ_TRAP_EN
  logic [29:0] epc_reg;
  logic        misalign;

  // A jr target that is not word aligned is treated as an exception.
  assign misalign = (npc_sel == 2'b11) && (rs_val[1:0] != 2'b00);
  assign epc      = epc_reg;
`else
  logic unused_trap;

  assign unused_trap = ^{exc, eret, rs_val[1:0], TRAP_VEC};
  assign epc         = '0;
`endif

  // Sequencer FSM: state, pc, latched instruction and registered handshake outputs.
  always_ff @(posedge clock) begin
    if (flag_reset) begin
      state_reg       <= IDLE;
      pc_reg          <= RESET_PC[31:2];
      instr_q_reg     <= '0;
      imem_req_reg    <= 1'b0;
      instr_valid_reg <= 1'b0;
`ifdef PC_SEQ_TRAP_EN
      epc_reg         <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg    <= FETCH;
          imem_req_reg <= 1'b1;
        end
        FETCH: begin
          if (imem_ack) begin
            instr_q_reg     <= instr;
            imem_req_reg    <= 1'b0;
            instr_valid_reg <= 1'b1;
            state_reg       <= DECODE;
          end
        end
        DECODE: begin
          instr_valid_reg <= 1'b0;
          state_reg       <= EXEC;
        end
        EXEC: begin
`ifdef PC_SEQ_TRAP_EN
          if (exc || misalign) begin
            epc_reg      <= pc_reg;
            pc_reg       <= TRAP_VEC[31:2];
            state_reg    <= FETCH;
            imem_req_reg <= 1'b1;
          end else if (eret) begin
            pc_reg       <= epc_reg;
            state_reg    <= FETCH;
            imem_req_reg <= 1'b1;
          end else if (!stall) begin
            pc_reg       <= npc_next;
            state_reg    <= FETCH;
            imem_req_reg <= 1'b1;
          end
`else
          if (!stall) begin
            pc_reg       <= npc_next;
            state_reg    <= FETCH;
            imem_req_reg <= 1'b1;
          end
`endif
        end
        default: begin
          state_reg       <= IDLE;
          imem_req_reg    <= 1'b0;
          instr_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign pc          = pc_reg;
  assign instr_q     = instr_q_reg;
  assign imem_req    = imem_req_reg;
  assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed, table-driven bench for pc_sequencer. Trap
// sequences are compiled only when PC_SEQ_TRAP_EN is defined.
module tb_pc_sequencer;

  logic        clock;
  logic        flag_reset;
  logic        imem_ack;
  logic [31:0] instr;
  logic [1:0]  npc_sel;
  logic        br_taken;
  logic [31:0] rs_val;
  logic        stall;
  logic        exc;
  logic        eret;
  logic [31:2] pc;
  logic        imem_req;
  logic [31:0] instr_q;
  logic        instr_valid;
  logic [31:2] epc;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:2] pc0;

  pc_sequencer dut (
    .clock       (clock),
    .flag_reset  (flag_reset),
    .imem_ack    (imem_ack),
    .instr       (instr),
    .npc_sel     (npc_sel),
    .br_taken    (br_taken),
    .rs_val      (rs_val),
    .stall       (stall),
    .exc         (exc),
    .eret        (eret),
    .pc          (pc),
    .imem_req    (imem_req),
    .instr_q     (instr_q),
    .instr_valid (instr_valid),
    .epc         (epc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] ins;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] rs;
    int          dly;
    int          stall_n;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for FETCH, ack after dly cycles, step through DECODE; returns at the EXEC negedge.
  task automatic to_exec(input logic [31:0] ins, input int dly);
    int guard;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    check("fetch_reached", {31'd0, imem_req}, 32'd1);
    pc0 = pc;
    imem_ack = 1'b0;
    for (int i = 0; i < dly; i++) begin
      @(negedge clock);
      check("req_hold", {31'd0, imem_req}, 32'd1);
      check("valid_in_fetch", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b1;
    instr    = ins;
    @(negedge clock);
    imem_ack = 1'b0;
    instr    = 32'hA5A5_5A5A;
    check("decode_valid", {31'd0, instr_valid}, 32'd1);
    check("decode_req", {31'd0, imem_req}, 32'd0);
    check("instr_q", instr_q, ins);
    check("pc_stable_decode", {pc, 2'b00}, {pc0, 2'b00});
    @(negedge clock);
    check("exec_valid", {31'd0, instr_valid}, 32'd0);
    check("exec_req", {31'd0, imem_req}, 32'd0);
  endtask

  // Drive EXEC controls, optionally stall, then check the new pc.
  task automatic finish_exec(input logic [1:0] sel, input logic br, input logic [31:0] rs,
                             input int stall_n, input logic [31:0] exp_pc);
    npc_sel  = sel;
    br_taken = br;
    rs_val   = rs;
    for (int i = 0; i < stall_n; i++) begin
      stall = 1'b1;
      @(negedge clock);
      check("stall_pc", {pc, 2'b00}, {pc0, 2'b00});
      check("stall_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    @(negedge clock);
    check("npc", {pc, 2'b00}, exp_pc);
    check("refetch_req", {31'd0, imem_req}, 32'd1);
    // Junk controls outside EXEC must have no effect.
    npc_sel  = 2'b11;
    br_taken = 1'b1;
    rs_val   = 32'hDEAD_BEE0;
  endtask

  initial begin
    vecs[0]  = '{32'h0000_0000, 2'b00, 1'b0, 32'h0,         1, 0, 32'h0000_3004};
    vecs[1]  = '{32'h0000_0C04, 2'b10, 1'b0, 32'h0,         0, 0, 32'h0000_3010};
    vecs[2]  = '{32'h0000_FFFC, 2'b01, 1'b1, 32'h0,         2, 0, 32'h0000_3004};
    vecs[3]  = '{32'h0000_0C04, 2'b10, 1'b0, 32'h0,         0, 5, 32'h0000_3010};
    vecs[4]  = '{32'h0000_FFFC, 2'b01, 1'b0, 32'h0,         3, 0, 32'h0000_3014};
    vecs[5]  = '{32'h0000_0C00, 2'b10, 1'b0, 32'h0,         0, 0, 32'h0000_3000};
    vecs[6]  = '{32'h0000_0400, 2'b10, 1'b0, 32'h0,         0, 0, 32'h0000_1000};
    vecs[7]  = '{32'h0000_0000, 2'b11, 1'b0, 32'h0040_0020, 1, 0, 32'h0040_0020};
    vecs[8]  = '{32'h1234_8001, 2'b00, 1'b1, 32'h0,         0, 0, 32'h0040_0024};
    vecs[9]  = '{32'h0000_0010, 2'b01, 1'b1, 32'h0,         0, 0, 32'h0040_0068};
    vecs[10] = '{32'h0000_0000, 2'b11, 1'b0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC};
    vecs[11] = '{32'h0000_0000, 2'b00, 1'b0, 32'h0,         0, 2, 32'h0000_0000};
    vecs[12] = '{32'h0000_0000, 2'b11, 1'b0, 32'hF000_0000, 0, 0, 32'hF000_0000};
    vecs[13] = '{32'h03FF_FFFF, 2'b10, 1'b0, 32'h0,         0, 0, 32'hFFFF_FFFC};
    vecs[14] = '{32'h0000_7FFF, 2'b01, 1'b1, 32'h0,         0, 0, 32'h0001_FFFC};

    flag_reset = 1'b1;
    imem_ack   = 1'b0;
    instr      = 32'h0;
    npc_sel    = 2'b00;
    br_taken   = 1'b0;
    rs_val     = 32'h0;
    stall      = 1'b0;
    exc        = 1'b0;
    eret       = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_pc", {pc, 2'b00}, 32'h0000_3000);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr_q", instr_q, 32'h0);
    check("rst_epc", {epc, 2'b00}, 32'h0);
    flag_reset = 1'b0;

    for (int v = 0; v < 15; v++) begin
      to_exec(vecs[v].ins, vecs[v].dly);
      finish_exec(vecs[v].sel, vecs[v].br, vecs[v].rs, vecs[v].stall_n, vecs[v].exp_pc);
      $display("vec %0d: sel=%b br=%b dly=%0d stall=%0d pc=%h exp=%h", v, vecs[v].sel,
               vecs[v].br, vecs[v].dly, vecs[v].stall_n, {pc, 2'b00}, vecs[v].exp_pc);
    end

    // Reset in the middle of FETCH while ack is withheld.
    imem_ack   = 1'b0;
    @(negedge clock);
    check("midfetch_req_before", {31'd0, imem_req}, 32'd1);
    flag_reset = 1'b1;
    @(negedge clock);
    flag_reset = 1'b0;
    check("midfetch_rst_pc", {pc, 2'b00}, 32'h0000_3000);
    check("midfetch_rst_req", {31'd0, imem_req}, 32'd0);
    check("midfetch_rst_instr_q", instr_q, 32'h0);
    @(negedge clock);
    check("idle_to_fetch_req", {31'd0, imem_req}, 32'd1);
    $display("seq reset_mid_fetch: pc=%h imem_req=%b", {pc, 2'b00}, imem_req);

    // Reset while stalled in EXEC.
    to_exec(32'h0000_0C04, 0);
    npc_sel = 2'b10;
    stall   = 1'b1;
    repeat (2) @(negedge clock);
    flag_reset = 1'b1;
    @(negedge clock);
    flag_reset = 1'b0;
    stall      = 1'b0;
    check("stallrst_pc", {pc, 2'b00}, 32'h0000_3000);
    check("stallrst_req", {31'd0, imem_req}, 32'd0);
    check("stallrst_instr_q", instr_q, 32'h0);
    to_exec(32'h0, 0);
    finish_exec(2'b00, 1'b0, 32'h0, 0, 32'h0000_3004);
    $display("seq reset_in_stall: pc=%h", {pc, 2'b00});

`ifdef PC_SEQ_TRAP_EN
    to_exec(32'h0000_0C02, 0);
    finish_exec(2'b10, 1'b0, 32'h0, 0, 32'h0000_3008);
    to_exec(32'h0, 0);
    npc_sel = 2'b00;
    exc     = 1'b1;
    stall   = 1'b1;
    @(negedge clock);
    exc     = 1'b0;
    stall   = 1'b0;
    check("trap_epc", {epc, 2'b00}, 32'h0000_3008);
    check("trap_pc", {pc, 2'b00}, 32'h0000_4180);
    $display("seq trap: pc=%h epc=%h", {pc, 2'b00}, {epc, 2'b00});
    to_exec(32'h0, 0);
    eret  = 1'b1;
    stall = 1'b1;
    @(negedge clock);
    eret  = 1'b0;
    stall = 1'b0;
    check("eret_pc", {pc, 2'b00}, 32'h0000_3008);
    $display("seq eret: pc=%h", {pc, 2'b00});
    to_exec(32'h0, 0);
    npc_sel = 2'b11;
    rs_val  = 32'h0000_3002;
    @(negedge clock);
    check("misalign_pc", {pc, 2'b00}, 32'h0000_4180);
    check("misalign_epc", {epc, 2'b00}, 32'h0000_3008);
    $display("seq misalign: pc=%h epc=%h", {pc, 2'b00}, {epc, 2'b00});
`else
    to_exec(32'h0, 0);
    exc = 1'b1;
    eret = 1'b1;
    finish_exec(2'b00, 1'b0, 32'h0, 0, 32'h0000_3008);
    exc  = 1'b0;
    eret = 1'b0;
    check("no_trap_epc", {epc, 2'b00}, 32'h0);
    $display("seq no_trap: pc=%h epc=%h", {pc, 2'b00}, {epc, 2'b00});
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
